// File: rtl/warp_pc_ctrl.sv
// warp_pc_ctrl: warp-wide PC sequencing with per-lane NZP, SIMT SYNC routing and RET retirement
module warp_pc_ctrl #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [2:0] core_state,
  input  logic [2:0] decoded_nzp,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] decoded_immediate,
  input  logic decoded_pc_mux,
  input  logic decoded_nzp_write_enable,
  input  logic decoded_ssy,
  input  logic decoded_sync,
  input  logic decoded_ret,
  input  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] alu_out,
  input  logic [THREADS_PER_BLOCK-1:0] thread_mask,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] branch_pc,
  input  logic [1:0] remain_route,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [THREADS_PER_BLOCK*3-1:0] nzp,
  output logic branch_taken,
  output logic done,
  output logic sync_underflow
);
  localparam int PW = PROGRAM_MEM_ADDR_BITS;
  localparam int T = THREADS_PER_BLOCK;
  localparam int D = DATA_MEM_DATA_BITS;
  logic is_exec, is_update, sync_hit, branch_hit, exec_taken, exec_underflow;
  logic [PW-1:0] pc_inc, exec_pc;
  logic [T*3-1:0] nzp_d;
  assign is_exec = core_state == 3'b101;
  assign is_update = core_state == 3'b110;
  assign pc_inc = current_pc + PW'(1);
  // remain_route==3 is not a SYNC case, so such an instruction falls through to the SSY/branch rules
  assign sync_hit = decoded_sync && remain_route != 2'd3;
  always_comb begin
    branch_hit = 1'b0;
    nzp_d = nzp;
    for (int i = 0; i < T; i++) begin
      branch_hit = branch_hit | (thread_mask[i] && |(nzp[3*i +: 3] & decoded_nzp));
      nzp_d[3*i +: 3] = thread_mask[i] ? alu_out[D*i +: 3] : nzp[3*i +: 3];
    end
  end
  always_comb begin
    exec_pc = pc_inc;
    exec_taken = 1'b0;
    exec_underflow = 1'b0;
    if (decoded_ret)
      exec_pc = current_pc;
    else if (sync_hit && remain_route == 2'd2) begin
      exec_pc = branch_pc;
      exec_taken = 1'b1;
    end else if (sync_hit)
      exec_underflow = remain_route == 2'd0;
    else if (!decoded_ssy && decoded_pc_mux && branch_hit) begin
      exec_pc = decoded_immediate;
      exec_taken = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      current_pc <= '0;
      next_pc <= '0;
      nzp <= '0;
      branch_taken <= 1'b0;
      done <= 1'b0;
      sync_underflow <= 1'b0;
    end else if (enable) begin
      if (is_exec) begin
        branch_taken <= exec_taken;
        if (exec_underflow) sync_underflow <= 1'b1;
        if (!done) next_pc <= exec_pc;
      end
      if (is_update && !done) begin
        current_pc <= next_pc;
        if (decoded_nzp_write_enable) nzp <= nzp_d;
      end
      if (is_update && decoded_ret) done <= 1'b1;
    end
  end
endmodule

// File: doc/warp_pc_ctrl.md
WARP_PC_CTRL -- requirements
Module: warp_pc_ctrl

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8: program counter width.
REQ-002 Parameter DATA_MEM_DATA_BITS, default 8: per-thread ALU result width; at least 3.
REQ-003 Parameter THREADS_PER_BLOCK, default 4: lanes sharing one PC.
REQ-004 clk  in  1  the block's only clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  block active; when low, all registers hold.
REQ-007 core_state  in  3  core FSM state; 3'b101 is EXECUTE, 3'b110 is UPDATE, other values are ignored.
REQ-008 decoded_nzp  in  3  branch, SSY and SYNC condition mask.
REQ-009 decoded_immediate  in  PROGRAM_MEM_ADDR_BITS  branch target.
REQ-010 decoded_pc_mux  in  1  BRnzp instruction.
REQ-011 decoded_nzp_write_enable  in  1  CMP result writeback.
REQ-012 decoded_ssy, decoded_sync, decoded_ret  in  1 each  instruction flags.
REQ-013 alu_out  in  THREADS_PER_BLOCK*DATA_MEM_DATA_BITS  per-lane ALU result, lane i at slice i; bits [2:0] of each slice are the NZP code.
REQ-014 thread_mask  in  THREADS_PER_BLOCK  active lanes, from the SIMT stack.
REQ-015 branch_pc  in  PROGRAM_MEM_ADDR_BITS  reconvergence/alternate-path PC, from the SIMT stack.
REQ-016 remain_route  in  2  remaining divergent paths, from the SIMT stack.
REQ-017 current_pc  out  PROGRAM_MEM_ADDR_BITS  PC of the instruction being executed.
REQ-018 next_pc  out  PROGRAM_MEM_ADDR_BITS  registered next PC.
REQ-019 nzp  out  THREADS_PER_BLOCK*3  per-lane NZP registers, lane i at bits [3i+2:3i], consumed by the SIMT stack.
REQ-020 branch_taken  out  1  registered; the last EXECUTE resolved to a non-sequential PC.
REQ-021 done  out  1  RET retired.
REQ-022 sync_underflow  out  1  sticky error flag.

Function
REQ-023 All outputs SHALL update only when enable=1 and reset=0.
REQ-024 In EXECUTE, next_pc SHALL be selected by the first matching rule, in this priority order:
- decoded_ret: current_pc.
- decoded_sync with remain_route==2: branch_pc as sampled in the same cycle; branch_taken=1.
- decoded_sync with remain_route==1: current_pc+1.
- decoded_sync with remain_route==0: current_pc+1; sync_underflow set.
- decoded_ssy: current_pc+1.
- decoded_pc_mux: decoded_immediate if any lane i has thread_mask[i]=1 and (nzp lane i & decoded_nzp)!=0, with branch_taken=1; otherwise current_pc+1.
- None of the above: current_pc+1.
REQ-025 branch_taken SHALL be rewritten in every EXECUTE cycle: 1 only for the taken cases in REQ-024, otherwise 0.
REQ-026 current_pc+1 SHALL wrap modulo 2^PROGRAM_MEM_ADDR_BITS, so the maximum PC is followed by 0.
REQ-027 If thread_mask is all zero, a BRnzp SHALL resolve not-taken.
REQ-028 In UPDATE, current_pc SHALL load next_pc, unless done=1, in which case it holds.
REQ-029 In UPDATE with decoded_nzp_write_enable=1, nzp lane i SHALL load alu_out lane i bits [2:0] only where thread_mask[i]=1; masked lanes hold.
REQ-030 NZP codes SHALL be stored unchecked; non-one-hot values are allowed.
REQ-031 In UPDATE with decoded_ret=1, done SHALL set and stay set until reset.
REQ-032 Once done=1, current_pc, next_pc and nzp SHALL freeze.
REQ-033 sync_underflow SHALL stay set until reset.
REQ-034 Latency: a BRnzp target is visible on next_pc one clock after EXECUTE, and on current_pc one clock after UPDATE.

Reset
REQ-035 On reset=1 at a clock edge, the block SHALL set: current_pc=0, next_pc=0, nzp all 3'b000, branch_taken=0, done=0, sync_underflow=0.
REQ-036 Reset SHALL take priority over enable and core_state, including when asserted mid-instruction.
REQ-037 The first non-reset cycle SHALL behave normally.

Verification
REQ-038 Sequential flow: enable=1, four EXECUTE/UPDATE pairs with no flags -> current_pc goes 1,2,3,4; branch_taken=0.
REQ-039 Masked CMP and branch: thread_mask=4'b0101, CMP with lane results 3'b001/3'b100/3'b010/3'b100 -> nzp lanes 0 and 2 update, lanes 1 and 3 hold 0; then BRnzp with decoded_nzp=3'b010, immediate=8'h20 -> next_pc=8'h20, branch_taken=1.
REQ-040 SYNC routing: current_pc=8'h10, branch_pc=8'h30, remain_route=2, SYNC -> next_pc=8'h30; then remain_route=1, SYNC -> next_pc=current_pc+1; then remain_route=0, SYNC -> sync_underflow=1.
REQ-041 Wrap and RET: current_pc=8'hFF, plain instruction -> current_pc=8'h00; then RET -> done=1, and a following UPDATE leaves current_pc unchanged.
REQ-042 Reset mid-operation: reset asserted during UPDATE with current_pc=8'h42 and done=1 -> every output at its REQ-035 value on the next clock.
REQ-043 enable=0 held for 3 cycles during EXECUTE/UPDATE -> no output changes.
